// File: rtl/dia_pkg.sv
// Shared day-of-week definitions: index encoding, BCD mapping and the controller state set.
package dia_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EDIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [2:0] DIA_DOMINGO = 3'd0;
  localparam logic [2:0] DIA_LUNES   = 3'd1;
  localparam logic [2:0] DIA_MARTES  = 3'd2;
  localparam logic [2:0] DIA_MIERC   = 3'd3;
  localparam logic [2:0] DIA_JUEVES  = 3'd4;
  localparam logic [2:0] DIA_VIERNES = 3'd5;
  localparam logic [2:0] DIA_SABADO  = 3'd6;
  localparam logic [2:0] DIA_MAX     = DIA_SABADO;

  // RTC day register is BCD 1..7 with 1 = Domingo.
  localparam logic [7:0] BCD_DIA_MIN = 8'h01;
  localparam logic [7:0] BCD_DIA_MAX = 8'h07;

  function automatic logic bcd_day_ok(input logic [7:0] b);
    return (b >= BCD_DIA_MIN) && (b <= BCD_DIA_MAX);
  endfunction

  function automatic logic [2:0] bcd_to_idx(input logic [7:0] b);
    return b[2:0] - 3'd1;
  endfunction

  function automatic logic [7:0] idx_to_bcd(input logic [2:0] i);
    return {5'd0, i} + BCD_DIA_MIN;
  endfunction

  function automatic logic [2:0] dia_inc(input logic [2:0] i);
    return (i == DIA_MAX) ? DIA_DOMINGO : i + 3'd1;
  endfunction

  function automatic logic [2:0] dia_dec(input logic [2:0] i);
    return (i == DIA_DOMINGO) ? DIA_MAX : i - 3'd1;
  endfunction

endpackage

// File: rtl/ctrl_dia_if.sv
// Signal bundle between the day controller and its surroundings (tick, RTC, buttons, decoder).
interface ctrl_dia_if;
  logic       day_tick;
  logic       load_valid;
  logic [7:0] load_day;
  logic       edit_en;
  logic       btn_up;
  logic       btn_down;
  logic       wr_ack;
  logic [2:0] dia_idx;
  logic       dia_en;
  logic       wr_req;
  logic [7:0] wr_day;
  logic       err;

  modport master (
    output day_tick, load_valid, load_day, edit_en, btn_up, btn_down, wr_ack,
    input  dia_idx, dia_en, wr_req, wr_day, err
  );

  modport slave (
    input  day_tick, load_valid, load_day, edit_en, btn_up, btn_down, wr_ack,
    output dia_idx, dia_en, wr_req, wr_day, err
  );
endinterface

// File: rtl/ctrl_dia_det_flanco.sv
// 1-bit edge detector against the previous-cycle sample; combinational outputs, no added latency.
module det_flanco (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= d;
  end

  assign rise = d & ~prev;
  assign fall = ~d & prev;
endmodule

// File: rtl/ctrl_dia.sv
// Day-of-week register/controller feeding the day decoder and the RTC write path.
module ctrl_dia
  import dia_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  ctrl_dia_if.slave  bus
);

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic       valid, valid_n;
  logic       wr_req, wr_req_n;
  logic [7:0] wr_day, wr_day_n;
  logic       err, err_n;
  logic [7:0] cnt, cnt_n;

  logic up_rise, up_fall, dn_rise, dn_fall, ed_rise, ed_fall;
  logic unused_fall;

  det_flanco u_det_up   (.clk(clk), .reset(reset), .d(bus.btn_up),   .rise(up_rise), .fall(up_fall));
  det_flanco u_det_down (.clk(clk), .reset(reset), .d(bus.btn_down), .rise(dn_rise), .fall(dn_fall));
  det_flanco u_det_edit (.clk(clk), .reset(reset), .d(bus.edit_en),  .rise(ed_rise), .fall(ed_fall));

  assign unused_fall = up_fall ^ dn_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      idx    <= DIA_DOMINGO;
      valid  <= 1'b0;
      wr_req <= 1'b0;
      wr_day <= BCD_DIA_MIN;
      err    <= 1'b0;
      cnt    <= 8'd0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      valid  <= valid_n;
      wr_req <= wr_req_n;
      wr_day <= wr_day_n;
      err    <= err_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    valid_n  = valid;
    wr_req_n = wr_req;
    wr_day_n = wr_day;
    err_n    = 1'b0;
    cnt_n    = cnt;
    unique case (state)
      ST_IDLE: begin
        // Entering edit swallows any tick or load in the same cycle.
        if (ed_rise) begin
          state_n = ST_EDIT;
        end else if (bus.load_valid) begin
          if (bcd_day_ok(bus.load_day)) begin
            idx_n   = bcd_to_idx(bus.load_day);
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else if (bus.day_tick) begin
          idx_n = dia_inc(idx);
        end
      end
      ST_EDIT: begin
        if (ed_fall) begin
          wr_day_n = idx_to_bcd(idx);
          wr_req_n = 1'b1;
          cnt_n    = 8'd0;
          state_n  = ST_WRITE;
        end else if (up_rise && !dn_rise) begin
          idx_n = dia_inc(idx);
        end else if (dn_rise && !up_rise) begin
          idx_n = dia_dec(idx);
        end
      end
      ST_WRITE: begin
        if (bus.wr_ack) begin
          wr_req_n = 1'b0;
          valid_n  = 1'b1;
          state_n  = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          wr_req_n = 1'b0;
          err_n    = 1'b1;
          state_n  = ST_IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.dia_idx = idx;
  assign bus.dia_en  = valid;
  assign bus.wr_req  = wr_req;
  assign bus.wr_day  = wr_day;
  assign bus.err     = err;

endmodule
